// File: rtl/moore_counter_scheduler.sv
// Round-robin scheduler that lends one shared 2-bit Moore counter
// to NREQ requesters: clear, run for a requested length, release.
module moore_counter_scheduler #(
    parameter int NREQ  = 4,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    input  logic [LEN_W-1:0] run_len,
    output logic [NREQ-1:0]  gnt,
    output logic             busy,
    output logic [1:0]       cnt,
    output logic             out,
    output logic             done,
    output logic             aborted
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);
    localparam logic [IW-1:0] LAST = IW'(NREQ - 1);
    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             abort_q, abort_d;

    logic             found;
    logic [IW-1:0]    pick;
    logic [IW:0]      sum;
    logic [IW-1:0]    idx;
    logic             owner_req;
    logic             last_step;

    // First requester at or above ptr, wrapping past NREQ-1.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr_q} + (IW+1)'(i);
            if (sum >= NREQ_W) begin
                sum = sum - NREQ_W;
            end
            idx = sum[IW-1:0];
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign owner_req = req[owner_q];
    assign last_step = (rem_q == ONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: state_d = S_RUN;
            S_RUN: begin
                if (!owner_req || last_step) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= '0;
            owner_q <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        owner_d = owner_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        abort_d = abort_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                abort_d = 1'b0;
                if (found) begin
                    owner_d = pick;
                    rem_d   = (run_len == '0) ? ONE : run_len;
                end
            end
            S_CLEAR: cnt_d = '0;
            S_RUN: begin
                // A dropped request wins over the normal end; cnt freezes.
                if (!owner_req) begin
                    abort_d = 1'b1;
                end else if (!last_step) begin
                    cnt_d = cnt_q + 2'd1;
                    rem_d = rem_q - ONE;
                end
            end
            S_DONE: begin
                cnt_d = '0;
                ptr_d = (owner_q == LAST) ? '0 : owner_q + IW'(1);
            end
            default: cnt_d = '0;
        endcase
    end

    always_comb begin
        gnt     = '0;
        busy    = 1'b0;
        out     = 1'b0;
        done    = 1'b0;
        aborted = 1'b0;
        cnt     = cnt_q;
        unique case (state_q)
            S_IDLE: ;
            S_CLEAR: begin
                busy = 1'b1;
                gnt  = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;
            end
            S_RUN: begin
                busy = 1'b1;
                gnt  = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;
                out  = (cnt_q == 2'b10);
            end
            S_DONE: begin
                busy    = 1'b1;
                gnt     = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;
                done    = 1'b1;
                aborted = abort_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_moore_counter_scheduler.sv
// Scoreboard bench for moore_counter_scheduler: stimulus queues one
// expected record per run, the monitor rebuilds runs from the outputs.
module tb_moore_counter_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] run_len = '0;
    logic [3:0] gnt;
    logic       busy;
    logic [1:0] cnt;
    logic       out;
    logic       done;
    logic       aborted;

    moore_counter_scheduler #(.NREQ(4), .LEN_W(4)) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .run_len(run_len),
        .gnt(gnt),
        .busy(busy),
        .cnt(cnt),
        .out(out),
        .done(done),
        .aborted(aborted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] gnt;
        logic       ab;
        logic [1:0] cnt;
        logic [7:0] len;
        logic [7:0] outs;
        logic [7:0] pos;
        logic [7:0] gap;
    } rec_t;

    rec_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic rec_t mk(input logic [3:0] g, input logic a,
                                input logic [1:0] c, input int l,
                                input int o, input int p, input int gp);
        rec_t r;
        r.gnt  = g;
        r.ab   = a;
        r.cnt  = c;
        r.len  = 8'(l);
        r.outs = 8'(o);
        r.pos  = 8'(p);
        r.gap  = 8'(gp);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: rebuild each run from gnt/busy/out/done and pop on done.
    bit         mon_active = 1'b0;
    rec_t       cur;
    rec_t       e;
    logic [7:0] gap_ctr = 8'hFF;

    always @(negedge clk) begin
        if (reset) begin
            mon_active = 1'b0;
            gap_ctr    = 8'hFF;
        end else begin
            chk("gnt_onehot0", 32'($onehot0(gnt)), 1);
            chk("busy_vs_gnt", 32'(busy), 32'(|gnt));
            if (busy && !mon_active) begin
                mon_active = 1'b1;
                cur        = '0;
                cur.gnt    = gnt;
                cur.gap    = gap_ctr;
            end
            if (mon_active) begin
                chk("gnt_stable", gnt, cur.gnt);
                cur.len = cur.len + 8'd1;
                if (out) begin
                    cur.outs = cur.outs + 8'd1;
                    if (cur.pos == 0) cur.pos = cur.len;
                end
                cur.cnt = cnt;
                cur.ab  = aborted;
                if (done) begin
                    mon_active = 1'b0;
                    gap_ctr    = 8'd0;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got gnt=%b expected none",
                                 cur.gnt);
                    end else begin
                        e = sb.pop_front();
                        chk("run_gnt", cur.gnt, e.gnt);
                        chk("run_aborted", cur.ab, e.ab);
                        chk("run_cnt_at_done", cur.cnt, e.cnt);
                        chk("run_busy_len", cur.len, e.len);
                        chk("run_out_count", cur.outs, e.outs);
                        chk("run_out_pos", cur.pos, e.pos);
                        if (e.gap != 8'hFF) chk("run_idle_gap", cur.gap, e.gap);
                    end
                end
            end else begin
                if (done) begin
                    checks++;
                    errors++;
                    $display("FAIL done_while_idle: got done=1 expected 0");
                end
                if (gap_ctr != 8'hFF) gap_ctr = gap_ctr + 8'd1;
            end
        end
    end

    task automatic wait_done(input string nm);
        bit seen = 1'b0;
        for (int n = 0; n < 64 && !seen; n++) begin
            @(negedge clk);
            seen = done;
        end
        chk({nm, "_timeout"}, 32'(seen), 1);
    endtask

    // Called at a negedge; leaves the bench one cycle after done.
    task automatic do_run(input logic [3:0] r, input logic [3:0] l,
                          input rec_t x);
        req     = r;
        run_len = l;
        sb.push_back(x);
        @(negedge clk);
        chk("grant_latency", gnt, x.gnt);
        wait_done("run_done");
        req     = '0;
        run_len = '0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset and idle
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_idle", {gnt, busy, cnt, out, done, aborted}, 0);
        end

        // 2: single run of 5
        do_run(4'b0001, 4'd5, mk(4'b0001, 0, 2'b00, 7, 1, 4, 255));

        // 3: three requesters held, from a fresh pointer
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        req     = 4'b1011;
        run_len = 4'd2;
        sb.push_back(mk(4'b0001, 0, 2'b01, 4, 0, 0, 255));
        sb.push_back(mk(4'b0010, 0, 2'b01, 4, 0, 0, 1));
        sb.push_back(mk(4'b1000, 0, 2'b01, 4, 0, 0, 1));
        sb.push_back(mk(4'b0001, 0, 2'b01, 4, 0, 0, 1));
        for (int k = 0; k < 4; k++) wait_done("rr_done");
        req     = '0;
        run_len = '0;
        @(negedge clk);

        // 4: run_len 0 means one RUN cycle
        do_run(4'b0100, 4'd0, mk(4'b0100, 0, 2'b00, 3, 0, 0, 255));

        // 5: abort on third RUN cycle
        req     = 4'b0100;
        run_len = 4'd8;
        sb.push_back(mk(4'b0100, 1, 2'b10, 5, 1, 4, 255));
        @(negedge clk);
        chk("abort_clear_gnt", gnt, 4'b0100);
        repeat (3) @(negedge clk);
        chk("abort_run3_cnt", cnt, 2'b10);
        req = '0;
        @(negedge clk);
        chk("abort_done", {done, aborted, cnt}, 4'b1110);
        @(negedge clk);
        chk("abort_released", {gnt, busy}, 0);

        // maximum run length
        do_run(4'b0010, 4'd15, mk(4'b0010, 0, 2'b10, 17, 4, 4, 255));

        // 6: reset in RUN with cnt=01, then restart from req[0]
        req     = 4'b1000;
        run_len = 4'd8;
        @(negedge clk);
        chk("rst_run_gnt", gnt, 4'b1000);
        repeat (2) @(negedge clk);
        chk("rst_run_cnt", cnt, 2'b01);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_run", {gnt, busy, cnt, done, aborted}, 0);
        @(negedge clk);
        reset = 1'b0;
        do_run(4'b1001, 4'd3, mk(4'b0001, 0, 2'b10, 5, 1, 4, 255));

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/moore_counter_scheduler.md
Name: moore_counter_scheduler

Overview:
Shares one 2-bit Moore counter (states 00→01→10→11→00; out=1 only in state 10) among NREQ requesters. A round-robin arbiter grants the counter to one requester at a time. The block clears the counter, runs it for a requested number of steps, then signals completion and releases it. It sits between client request logic and the shared counter datapath, and owns the counter register internally.

Parameters:
NREQ, 4, number of requesters (2..8)
LEN_W, 4, width of run-length input

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; clears all state on the next rising edge
req  input  NREQ  per-requester request level; held high for the whole run
run_len  input  LEN_W  requested number of RUN cycles, sampled at grant
gnt  output  NREQ  one-hot grant (registered); all-zero when idle
busy  output  1  high in CLEAR, RUN and DONE
cnt  output  2  shared counter state
out  output  1  Moore output: 1 iff state==RUN and cnt==2'b10
done  output  1  one-cycle pulse in DONE
aborted  output  1  high with done when the run ended early

Behaviour:
- Reset values: gnt=0, busy=0, cnt=00, out=0, done=0, aborted=0, FSM=IDLE, rr pointer=0 (req[0] has highest priority first), remaining=0, owner=0.
- FSM states: IDLE, CLEAR, RUN, DONE.
- IDLE: gnt=0, cnt held at 00.
  - If req!=0, select the first set bit searching upward from ptr with wrap, then go to CLEAR.
  - On that edge: latch owner and latch remaining = (run_len==0) ? 1 : run_len.
- CLEAR: one cycle. gnt[owner]=1, cnt forced to 00 on exit. Go to RUN.
- RUN: gnt[owner]=1, one counter step per cycle.
  - First RUN cycle shows cnt=00.
  - On each edge with remaining>1: cnt<=cnt+1 (mod 4, 11→00 wrap) and remaining<=remaining-1.
  - When remaining==1: cnt holds and the FSM goes to DONE.
  - The number of RUN cycles equals remaining as latched.
- Abort: in RUN, if req[owner]==0 on any cycle, go to DONE on the next edge with aborted set. cnt holds. Abort takes priority over the normal end.
- DONE: one cycle. done=1, aborted valid, gnt[owner] still 1, cnt held.
  - On exit: ptr<=owner+1 (mod NREQ), cnt<=00, go to IDLE.
- Grant latency: req rises in cycle T (IDLE), gnt rises in T+1 (CLEAR), first RUN cycle is T+2.
  - Minimum gap between two grants is one IDLE cycle.
- Arbitration rules:
  - Requests arriving during CLEAR, RUN or DONE wait.
  - req and run_len are not sampled outside IDLE.
  - Requests from non-owners never disturb an active run.
  - A requester still holding req after DONE re-enters arbitration at lowest priority.
- Simultaneous requests: strict round-robin from ptr. No starvation; each requester waits at most NREQ-1 runs.
- Reset mid-operation (any state) returns everything to reset values on the next edge. No done pulse is produced.
- Width rules:
  - cnt wraps modulo 4.
  - remaining is LEN_W bits and never underflows.
  - run_len = 2^LEN_W-1 gives the maximum run.
- gnt is always one-hot or zero.

Test Plan:
1. reset=1 for 2 cycles, then 0, with req=0 -> all outputs 0, FSM stays IDLE, cnt=00.
2. req=4'b0001, run_len=5 -> gnt=0001 in CLEAR; RUN shows cnt 00,01,10,11,00 with out=1 only on the third RUN cycle; done=1, aborted=0 next cycle; gnt=0 after DONE.
3. req=4'b1011 held, run_len=2 -> grant order 0,1,3,0,...; one IDLE cycle between runs; gnt never multi-hot.
4. req[2] only, run_len=0 -> exactly 1 RUN cycle with cnt=00, then done.
5. req=0100, run_len=8; drop req[2] on the 3rd RUN cycle -> DONE next edge, done=1, aborted=1, cnt held at 10.
6. reset asserted during RUN (cnt=01) -> next edge: gnt=0, cnt=00, busy=0, no done pulse; after release, arbitration restarts from req[0].
